rst_seq: RTL
============

// Module: rst_seq
// PURPOSE
//   Reset sequencer fed by the synchronised reset from the reset synchroniser.
//   Holds N_OUT downstream reset domains in reset for a minimum time after the
//   input reset releases. Then releases them one at a time, in fixed order, with a
//   programmable gap between releases.
//   Sits between the reset synchroniser and the block-level resets of the subsystem.
// PARAMETERS
//   N_OUT    = 4   number of sequenced reset outputs (>=1)
//   HOLD_CYC = 16  edges with rst_i low before rst_n_o[0] releases (>=1)
//   STEP_CYC = 8   edges between release of rst_n_o[k-1] and rst_n_o[k] (>=1)
// PORTS
//   clk_i       in   1      clock; single clock domain
//   rst_i       in   1      reset, synchronous, active-high
//   soft_req_i  in   1      soft-reset request, level
//   soft_ack_o  out  1      soft-reset acknowledge, 1-cycle pulse
//   rst_n_o     out  N_OUT  sequenced resets, active-low; bit 0 released first
//   done_o      out  1      high when all of rst_n_o are released
// BEHAVIOUR
//   - Reset values (rst_i=1): rst_n_o='0, done_o=0, soft_ack_o=0, state=S_HOLD,
//     timer loaded with HOLD_CYC, stage index=0. Reset wins over all other events.
//   - All outputs are registered. There is no combinational path from input to output.
//   - FSM S_HOLD -> S_STEP -> S_DONE:
//     S_HOLD: the timer decrements each edge.
//       On expiry, rst_n_o[0] is set to 1.
//       If N_OUT==1, the FSM goes to S_DONE. Otherwise it goes to S_STEP with the
//       timer loaded with STEP_CYC.
//     S_STEP: on each expiry, rst_n_o[idx+1] is set to 1 and idx increments.
//       After the last bit is set, the FSM goes to S_DONE.
//     S_DONE: outputs are stable; done_o=1.
//   - Timing: rst_n_o[0] rises on the HOLD_CYC-th edge with rst_i=0.
//     rst_n_o[k] rises exactly STEP_CYC edges after rst_n_o[k-1].
//     done_o rises on the same edge as rst_n_o[N_OUT-1].
//   - Released bits never re-assert, except on rst_i or an accepted soft reset.
//   - rst_i asserted mid-sequence: on the next edge all outputs return to their
//     reset values and the sequence restarts from S_HOLD.
//   - Timer width is $clog2(max(HOLD_CYC,STEP_CYC)+1). The timer uses unsigned
//     decrement and never wraps: reload happens on expiry.
//   - Illegal parameters (N_OUT, HOLD_CYC or STEP_CYC < 1) raise $error at
//     elaboration.
// CONFIGURATION
//   RST_SEQ_SOFT_RST_EN defined:
//     soft_req_i=1 while in S_DONE is accepted. On the next edge: rst_n_o='0,
//     done_o=0, soft_ack_o=1 for one cycle, FSM goes to S_HOLD with the HOLD_CYC
//     reload.
//     soft_req_i is ignored (no ack) in S_HOLD and S_STEP.
//     If the request is still held when S_DONE is reached again, it re-triggers.
//   RST_SEQ_SOFT_RST_EN undefined:
//     The ports remain present. soft_req_i is ignored and soft_ack_o is tied to 0.
// STRUCTURE
//   rst_seq_pkg holds:
//     typedef enum logic [1:0] {S_HOLD, S_STEP, S_DONE} rst_seq_state_t;
//     function tmr_width(hold, step) for the timer width.
//   Sub-module rst_seq_tmr: a loadable down-counter with a registered expiry flag.
//   One instance serves both the hold and step intervals.
// TESTING (N_OUT=4, HOLD_CYC=16, STEP_CYC=8 unless stated)
//   1. rst_i dropped at edge 0 -> rst_n_o = 0001 @16, 0011 @24, 0111 @32,
//      1111 @40; done_o=1 @40.
//   2. rst_i pulsed high at edge 28 -> rst_n_o=0000 and done_o=0 @29.
//      Full sequence restarts and completes 40 edges after rst_i drops.
//   3. Macro on: soft_req_i pulsed in S_DONE -> soft_ack_o pulses 1 cycle,
//      rst_n_o=0000 on the same edge, re-sequence completes 40 edges later.
//   4. Macro on: soft_req_i held high from edge 5 to edge 20 -> no ack,
//      sequence timing unchanged from scenario 1.
//   5. N_OUT=1, HOLD_CYC=1, STEP_CYC=1: rst_i drops at edge 0 ->
//      rst_n_o=1 and done_o=1 @1.
//   6. Macro off: soft_req_i pulsed in S_DONE -> outputs unchanged,
//      soft_ack_o stays 0.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the rst_seq reset sequencer.
// Holds the FSM state encoding and the timer-width calculation.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    S_HOLD,
    S_STEP,
    S_DONE
  } rst_seq_state_t;

  // The timer must be able to hold the larger of the two reload values.
  function automatic int tmr_width(input int hold, input int step);
    int m;
    m = (hold > step) ? hold : step;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_seq_tmr.sv
// Loadable down-counter with a registered expiry flag.
// expired is high while the count sits at 1, so the owner acts on the edge it reaches 0.
module rst_seq_tmr #(
  parameter int W       = 5,
  parameter int RST_VAL = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // NOTE: every variable driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= W'(RST_VAL);
      expired <= (RST_VAL == 1);
    end else begin
      cnt_q   <= cnt_d;
      expired <= (cnt_d == W'(1));
    end
  end

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds N_OUT reset domains, then releases them in order with a fixed gap.
// Optional soft reset from S_DONE is enabled by defining RST_SEQ_SOFT_RST_EN.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int N_OUT    = 4,
  parameter int HOLD_CYC = 16,
  parameter int STEP_CYC = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             soft_req_i,
  output logic             soft_ack_o,
  output logic [N_OUT-1:0] rst_n_o,
  output logic             done_o
);

  localparam int TMR_W = tmr_width(HOLD_CYC, STEP_CYC);
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(HOLD_CYC);
  localparam logic [TMR_W-1:0] STEP_LD  = TMR_W'(STEP_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((N_OUT > 1) ? N_OUT - 2 : 0);

  if (N_OUT < 1 || HOLD_CYC < 1 || STEP_CYC < 1) begin : g_bad_param
    $error("rst_seq: N_OUT, HOLD_CYC and STEP_CYC must all be >= 1");
  end

  rst_seq_state_t   state_q, state_d;
  logic [N_OUT-1:0] rst_n_q, rst_n_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             ack_q, ack_d;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_dec;
  logic             tmr_exp;

  rst_seq_tmr #(
    .W       (TMR_W),
    .RST_VAL (HOLD_CYC)
  ) u_tmr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .expired  (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    rst_n_d  = rst_n_q;
    idx_d    = idx_q;
    done_d   = done_q;
    ack_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = STEP_LD;
    tmr_dec  = 1'b0;
    unique case (state_q)
      S_HOLD: begin
        tmr_dec = 1'b1;
        if (tmr_exp) begin
          rst_n_d[0] = 1'b1;
          tmr_load   = 1'b1;
          idx_d      = '0;
          if (N_OUT == 1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        tmr_dec = 1'b1;
        if (tmr_exp) begin
          // Released bits form a thermometer code, so the next one shifts in from the bottom.
          rst_n_d  = N_OUT'({rst_n_q, 1'b1});
          idx_d    = idx_q + 1'b1;
          tmr_load = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
`ifdef RST_SEQ_SOFT_RST_EN
        if (soft_req_i) begin
          state_d  = S_HOLD;
          rst_n_d  = '0;
          idx_d    = '0;
          done_d   = 1'b0;
          ack_d    = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
`endif
      end
      default: begin
        state_d = S_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_HOLD;
      rst_n_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rst_n_q <= rst_n_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  assign rst_n_o = rst_n_q;
  assign done_o  = done_q;

`ifdef RST_SEQ_SOFT_RST_EN
  assign soft_ack_o = ack_q;
`else
  logic unused_soft;
  assign unused_soft = ^{soft_req_i, ack_q};
  assign soft_ack_o  = 1'b0;
`endif

endmodule
